// File: rtl/j11bus.sv
// DCJ11 bus interface: derives the J11 clock, decodes J11 address/control cycles
// on the multiplexed F bus and issues single-beat requests on the system bus.
module j11bus #(
  parameter int CLKDIV  = 5,
  parameter int FPHASE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  inout  wire  [15:0] j11f,
  output logic        j11clk,
  output logic        j11dmr,
  output logic        j11miss,
  output logic        j11cont,
  output logic        j11dv,
  output logic        j11abortout,
  output logic [3:0]  j11dsel,
  input  logic        j11ale,
  input  logic        j11strb,
  input  logic        j11sctl,
  input  logic        j11map,
  input  logic [3:0]  j11irq,
  input  logic        j11init,
  input  logic        j11halt,
  input  logic        j11pwrf,
  input  logic        j11fpe,
  input  logic        j11event,
  input  logic        j11parity,
  output logic        busreq,
  output logic        buswr,
  output logic        busgp,
  output logic [21:0] busaddr,
  output logic [15:0] buswdata,
  output logic [1:0]  busbs,
  input  logic        busack,
  input  logic        buserr,
  input  logic [15:0] busrdata,
  output logic [4:0]  j11state,
  output logic [7:0]  buserrcnt
);

  typedef enum logic [4:0] {
    ST_INIT, ST_IDLE, ST_WAITALE, ST_FETCHHI, ST_FETCHLO, ST_DECODE,
    ST_RDREQ, ST_RDOUT, ST_RDEND0, ST_RDEND1, ST_WRWAIT, ST_WRREQ,
    ST_WREND, ST_IRQACK, ST_ABORT, ST_OUTHI
  } state_t;

  localparam logic [3:0] DSEL_NONE  = 4'b1100;
  localparam logic [3:0] DSEL_INHI  = 4'b0100;
  localparam logic [3:0] DSEL_INLO  = 4'b1000;
  localparam logic [3:0] DSEL_OUTHI = 4'b1110;
  localparam logic [3:0] DSEL_OUTLO = 4'b1101;

  state_t      state_q, state_nx;
  logic [7:0]  ph_q, ph_nx;
  logic [15:0] div_q, tcnt_q;
  logic [3:0]  sync1_q, sync2_q;
  logic        strb_d_q;
  logic [15:0] hi, hi0_q, fout_q;
  logic [3:0]  aio_q;
  logic        abort_q, fdrive_q;
  logic        ale_s, strb_s, sctl_s, strb_rise, hi_chg;
  logic        ph_last, entered, mid, timeout;
  logic [3:0]  dsel_nx;
  logic        unused_map;

  assign j11dmr   = 1'b1;
  assign j11miss  = 1'b0;
  assign j11state = state_q;
  assign j11f     = fdrive_q ? fout_q : 16'bz;

  // Strobes from the J11 are asynchronous; idle level is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= 4'hF;
      sync2_q  <= 4'hF;
      strb_d_q <= 1'b1;
    end else begin
      sync1_q  <= {j11map, j11sctl, j11strb, j11ale};
      sync2_q  <= sync1_q;
      strb_d_q <= sync2_q[1];
    end
  end

  assign ale_s      = sync2_q[0];
  assign strb_s     = sync2_q[1];
  assign sctl_s     = sync2_q[2];
  assign unused_map = sync2_q[3];
  assign strb_rise  = strb_s & ~strb_d_q;

  assign hi     = {6'b0, j11parity, j11event, j11fpe, j11init, j11halt, j11pwrf, j11irq};
  assign hi_chg = (hi != hi0_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q  <= '0;
      j11clk <= 1'b0;
    end else if (div_q == 16'(CLKDIV - 1)) begin
      div_q  <= '0;
      j11clk <= ~j11clk;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  // The high fetch phase is two cycles shorter than the others.
  assign ph_last = (state_q == ST_FETCHHI) ? (ph_q == 8'(FPHASE - 3))
                                           : (ph_q == 8'(FPHASE - 1));
  assign timeout = (tcnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_INIT:    if (hi_chg) state_nx = ST_OUTHI;
      ST_IDLE:    if (strb_rise) state_nx = ST_WAITALE;
                  else if (hi_chg) state_nx = ST_OUTHI;
      ST_WAITALE: if (!ale_s) state_nx = ST_FETCHHI;
      ST_FETCHHI: if (ph_last) state_nx = ST_FETCHLO;
      ST_FETCHLO: if (ph_last) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (aio_q == 4'b1111)      state_nx = ST_WREND;
        else if (aio_q == 4'b1101) state_nx = ST_IRQACK;
        else if (abort_q)          state_nx = ST_WREND;
        else if (aio_q[3])         state_nx = ST_RDREQ;
        else                       state_nx = ST_WRWAIT;
      end
      // An ack in the timeout cycle wins over the timeout.
      ST_RDREQ: begin
        if (busack)       state_nx = buserr ? ST_ABORT : ST_RDOUT;
        else if (timeout) state_nx = ST_ABORT;
      end
      ST_WRREQ: begin
        if (busack)       state_nx = buserr ? ST_ABORT : ST_WREND;
        else if (timeout) state_nx = ST_ABORT;
      end
      ST_RDOUT:   if (ph_last) state_nx = ST_RDEND0;
      ST_RDEND0:  if (!sctl_s) state_nx = ST_RDEND1;
      ST_WRWAIT:  if (!sctl_s) state_nx = ST_WRREQ;
      ST_IRQACK:  if (sctl_s) state_nx = ST_IDLE;
      ST_RDEND1, ST_WREND, ST_ABORT:
                  if (sctl_s) state_nx = hi_chg ? ST_OUTHI : ST_IDLE;
      ST_OUTHI:   if (ph_last) state_nx = hi0_q[6] ? ST_IDLE : ST_INIT;
      default:    state_nx = ST_INIT;
    endcase
  end

  assign entered = (state_nx != state_q);
  assign ph_nx   = entered ? 8'd0 : ph_q + 8'd1;
  assign mid     = (ph_nx != 8'd0) && (ph_nx != 8'(FPHASE - 1));

  always_comb begin
    dsel_nx = DSEL_NONE;
    case (state_nx)
      ST_FETCHHI:           dsel_nx = DSEL_INHI;
      ST_FETCHLO, ST_WRWAIT: dsel_nx = DSEL_INLO;
      ST_RDOUT:             dsel_nx = mid ? DSEL_OUTLO : DSEL_NONE;
      ST_OUTHI:             dsel_nx = mid ? DSEL_OUTHI : DSEL_NONE;
      default:              dsel_nx = DSEL_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      ph_q        <= '0;
      j11dsel     <= DSEL_NONE;
      j11cont     <= 1'b1;
      j11dv       <= 1'b0;
      j11abortout <= 1'b0;
      fdrive_q    <= 1'b0;
      busreq      <= 1'b0;
      buswr       <= 1'b0;
      busgp       <= 1'b0;
      busaddr     <= '0;
      buswdata    <= '0;
      busbs       <= '0;
      buserrcnt   <= '0;
      aio_q       <= '0;
      abort_q     <= 1'b0;
      tcnt_q      <= '0;
      fout_q      <= '0;
      hi0_q       <= '0;
    end else begin
      state_q     <= state_nx;
      ph_q        <= ph_nx;
      j11dsel     <= dsel_nx;
      j11cont     <= !(state_nx == ST_RDEND1 || state_nx == ST_WREND || state_nx == ST_ABORT);
      j11dv       <= (state_nx == ST_RDEND1);
      j11abortout <= (state_nx == ST_ABORT);
      fdrive_q    <= (state_nx == ST_RDOUT || state_nx == ST_OUTHI);
      busreq      <= entered && (state_nx == ST_RDREQ || state_nx == ST_WRREQ);
      // First low-phase cycle still carries the high word through the external mux.
      if (state_q == ST_FETCHLO && ph_q == 8'd0) begin
        busaddr[21:16] <= j11f[5:0];
        busbs          <= j11f[7:6];
        aio_q          <= j11f[11:8];
        abort_q        <= j11f[13];
        busgp          <= (j11f[11:8] == 4'b1110) || (j11f[11:8] == 4'b0101);
      end
      if (state_q == ST_FETCHLO && ph_last) busaddr[15:0] <= j11f;
      if (entered && (state_nx == ST_RDREQ || state_nx == ST_WRREQ)) begin
        tcnt_q <= '0;
        buswr  <= (state_nx == ST_WRREQ);
      end else if (state_q == ST_RDREQ || state_q == ST_WRREQ) begin
        tcnt_q <= tcnt_q + 16'd1;
      end
      if (entered && state_nx == ST_WRREQ) buswdata <= j11f;
      if (state_q == ST_RDREQ && busack) begin
        fout_q <= busrdata;
      end else if (entered && state_nx == ST_OUTHI) begin
        fout_q <= hi;
        hi0_q  <= hi;
      end
      if (entered && state_nx == ST_ABORT && buserrcnt != 8'hFF)
        buserrcnt <= buserrcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_j11bus.sv
// Directed bench for j11bus: models the J11 strobes and an external F-bus mux
// that presents the address/data word selected by j11dsel one clock later.
module tb_j11bus;

  localparam int CLKDIV = 3, FPHASE = 4, TIMEOUT = 16;
  localparam logic [4:0] S_INIT = 5'd0, S_IDLE = 5'd1, S_WAITALE = 5'd2, S_DECODE = 5'd5,
    S_RDREQ = 5'd6, S_RDOUT = 5'd7, S_RDEND0 = 5'd8, S_RDEND1 = 5'd9, S_WRWAIT = 5'd10,
    S_WRREQ = 5'd11, S_WREND = 5'd12, S_IRQACK = 5'd13, S_ABORT = 5'd14, S_OUTHI = 5'd15;
  localparam logic [3:0] D_NONE = 4'b1100, D_INHI = 4'b0100, D_INLO = 4'b1000,
    D_OUTHI = 4'b1110, D_OUTLO = 4'b1101;

  logic clk = 1'b0, rstn;
  wire  [15:0] j11f;
  logic j11clk, j11dmr, j11miss, j11cont, j11dv, j11abortout;
  logic [3:0] j11dsel;
  logic j11ale, j11strb, j11sctl, j11map;
  logic [3:0] j11irq;
  logic j11init, j11halt, j11pwrf, j11fpe, j11event, j11parity;
  logic busreq, buswr, busgp, busack, buserr;
  logic [21:0] busaddr;
  logic [15:0] buswdata, busrdata;
  logic [1:0] busbs;
  logic [4:0] j11state;
  logic [7:0] buserrcnt;

  logic [15:0] f_hi = '0, f_lo = '0, mux_q = '0;
  logic mux_en = 1'b0;
  int vec = 0, errs = 0, req_cnt = 0;

  j11bus #(.CLKDIV(CLKDIV), .FPHASE(FPHASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .j11f(j11f), .j11clk(j11clk), .j11dmr(j11dmr),
    .j11miss(j11miss), .j11cont(j11cont), .j11dv(j11dv), .j11abortout(j11abortout),
    .j11dsel(j11dsel), .j11ale(j11ale), .j11strb(j11strb), .j11sctl(j11sctl),
    .j11map(j11map), .j11irq(j11irq), .j11init(j11init), .j11halt(j11halt),
    .j11pwrf(j11pwrf), .j11fpe(j11fpe), .j11event(j11event), .j11parity(j11parity),
    .busreq(busreq), .buswr(buswr), .busgp(busgp), .busaddr(busaddr),
    .buswdata(buswdata), .busbs(busbs), .busack(busack), .buserr(buserr),
    .busrdata(busrdata), .j11state(j11state), .buserrcnt(buserrcnt)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // External F-bus mux: registered, follows j11dsel with one clock of delay.
  always @(posedge clk) begin
    mux_en <= (j11dsel == D_INHI) || (j11dsel == D_INLO);
    mux_q  <= (j11dsel == D_INHI) ? f_hi : f_lo;
  end
  assign j11f = mux_en ? mux_q : 16'bz;

  always @(negedge clk) if (busreq === 1'b1) req_cnt = req_cnt + 1;

  task automatic wait_state(input logic [4:0] st, input int budget, input string name);
    int n = 0;
    while (j11state !== st && n < budget) begin @(negedge clk); n++; end
    vec++;
    if (j11state !== st) begin
      errs++; $display("FAIL %s: state %0d, required %0d within %0d cycles", name, j11state, st, budget);
    end
  endtask

  task automatic fetch(input logic [15:0] hw, input logic [15:0] lw, input string name);
    f_hi = hw; f_lo = lw;
    @(negedge clk); j11strb = 1'b1;
    wait_state(S_WAITALE, 8, {name, "_waitale"});
    j11ale = 1'b0;
    wait_state(S_DECODE, 20, {name, "_decode"});
    j11ale = 1'b1; j11strb = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (j11state !== S_INIT) begin errs++; $display("FAIL reset_state: got %0d required %0d", j11state, S_INIT); end
    vec++; if (j11cont !== 1'b1 || j11dv !== 1'b0 || j11abortout !== 1'b0) begin errs++; $display("FAIL reset_ctl: cont/dv/abort %b%b%b required 100", j11cont, j11dv, j11abortout); end
    vec++; if (j11dsel !== D_NONE) begin errs++; $display("FAIL reset_dsel: got %b required %b", j11dsel, D_NONE); end
    vec++; if (busreq !== 1'b0 || buswr !== 1'b0 || busgp !== 1'b0 || busaddr !== 22'h0 || buswdata !== 16'h0 || busbs !== 2'b0) begin errs++; $display("FAIL reset_bus: req %b wr %b gp %b addr %h wdata %h bs %b required all zero", busreq, buswr, busgp, busaddr, buswdata, busbs); end
    vec++; if (buserrcnt !== 8'h0 || j11clk !== 1'b0) begin errs++; $display("FAIL reset_cnt_clk: errcnt %0d j11clk %b required 0 0", buserrcnt, j11clk); end
    vec++; if (j11dmr !== 1'b1 || j11miss !== 1'b0) begin errs++; $display("FAIL const_pins: dmr %b miss %b required 1 0", j11dmr, j11miss); end
    rstn = 1'b1;
    wait_state(S_OUTHI, 4, "init_to_outhi");
    vec++; if (j11f !== 16'h0040) begin errs++; $display("FAIL init_status: F %h required 0040", j11f); end
    wait_state(S_IDLE, 8, "init_to_idle");
  endtask

  task automatic test_clkdiv();
    logic prev, v0, expv;
    int n = 0;
    prev = j11clk;
    while (j11clk === prev && n < 4 * CLKDIV) begin @(negedge clk); n++; end
    vec++; if (j11clk === prev) begin errs++; $display("FAIL clkdiv_toggle: j11clk stuck at %b", j11clk); end
    v0 = j11clk;
    for (int k = 1; k <= 4 * CLKDIV; k++) begin
      @(negedge clk);
      expv = v0 ^ 1'((k / CLKDIV) % 2);
      vec++; if (j11clk !== expv) begin errs++; $display("FAIL clkdiv_%0d: j11clk %b required %b", k, j11clk, expv); end
    end
  endtask

  task automatic test_read();
    int r0 = req_cnt;
    fetch(16'h08EA, 16'h1234, "rd");
    wait_state(S_RDREQ, 2, "rd_req");
    vec++; if (busreq !== 1'b1 || buswr !== 1'b0) begin errs++; $display("FAIL rd_busreq: req %b wr %b required 1 0", busreq, buswr); end
    vec++; if (busaddr !== 22'h2A1234 || busbs !== 2'b11 || busgp !== 1'b0) begin errs++; $display("FAIL rd_addr: addr %h bs %b gp %b required 2a1234 11 0", busaddr, busbs, busgp); end
    repeat (3) @(negedge clk);
    busack = 1'b1; busrdata = 16'hBEEF;
    @(negedge clk); busack = 1'b0;
    for (int i = 0; i < FPHASE; i++) begin
      vec++; if (j11state !== S_RDOUT || j11f !== 16'hBEEF) begin errs++; $display("FAIL rd_out_%0d: state %0d F %h required %0d beef", i, j11state, j11f, S_RDOUT); end
      vec++; if (j11dsel !== ((i == 1 || i == 2) ? D_OUTLO : D_NONE)) begin errs++; $display("FAIL rd_dsel_%0d: got %b", i, j11dsel); end
      @(negedge clk);
    end
    vec++; if (j11state !== S_RDEND0) begin errs++; $display("FAIL rd_end0: state %0d required %0d", j11state, S_RDEND0); end
    j11sctl = 1'b0;
    wait_state(S_RDEND1, 6, "rd_end1");
    @(negedge clk);
    vec++; if (j11dv !== 1'b1 || j11cont !== 1'b0) begin errs++; $display("FAIL rd_dv: dv %b cont %b required 1 0", j11dv, j11cont); end
    j11sctl = 1'b1;
    wait_state(S_IDLE, 6, "rd_idle");
    vec++; if (j11dv !== 1'b0 || j11cont !== 1'b1 || req_cnt - r0 != 1) begin errs++; $display("FAIL rd_done: dv %b cont %b reqs %0d required 0 1 1", j11dv, j11cont, req_cnt - r0); end
  endtask

  task automatic test_write();
    int r0 = req_cnt;
    fetch(16'h0441, 16'h2345, "wr");
    f_lo = 16'h5A5A;
    wait_state(S_WRWAIT, 2, "wr_wait");
    vec++; if (j11dsel !== D_INLO || req_cnt != r0) begin errs++; $display("FAIL wr_wait_dsel: dsel %b reqs %0d required %b 0", j11dsel, req_cnt - r0, D_INLO); end
    repeat (2) @(negedge clk);
    j11sctl = 1'b0;
    wait_state(S_WRREQ, 6, "wr_req");
    vec++; if (busreq !== 1'b1 || buswr !== 1'b1 || buswdata !== 16'h5A5A) begin errs++; $display("FAIL wr_busreq: req %b wr %b wdata %h required 1 1 5a5a", busreq, buswr, buswdata); end
    vec++; if (busaddr !== 22'h012345 || busbs !== 2'b01) begin errs++; $display("FAIL wr_addr: addr %h bs %b required 012345 01", busaddr, busbs); end
    @(negedge clk); busack = 1'b1;
    @(negedge clk); busack = 1'b0;
    @(negedge clk);
    vec++; if (j11state !== S_WREND || j11cont !== 1'b0) begin errs++; $display("FAIL wr_end: state %0d cont %b required %0d 0", j11state, j11cont, S_WREND); end
    j11sctl = 1'b1;
    wait_state(S_IDLE, 6, "wr_idle");
    vec++; if (j11cont !== 1'b1 || req_cnt - r0 != 1) begin errs++; $display("FAIL wr_done: cont %b reqs %0d required 1 1", j11cont, req_cnt - r0); end
  endtask

  task automatic test_timeout();
    fetch(16'h0801, 16'h0000, "to");
    wait_state(S_RDREQ, 2, "to_req");
    j11sctl = 1'b0;
    repeat (TIMEOUT - 1) @(negedge clk);
    vec++; if (j11state !== S_RDREQ || j11abortout !== 1'b0) begin errs++; $display("FAIL to_early: state %0d abort %b required %0d 0", j11state, j11abortout, S_RDREQ); end
    @(negedge clk);
    vec++; if (j11state !== S_ABORT || j11abortout !== 1'b1 || j11cont !== 1'b0 || j11dv !== 1'b0) begin errs++; $display("FAIL to_abort: state %0d abort %b cont %b dv %b required %0d 1 0 0", j11state, j11abortout, j11cont, j11dv, S_ABORT); end
    vec++; if (buserrcnt !== 8'd1) begin errs++; $display("FAIL to_errcnt: got %0d required 1", buserrcnt); end
    j11sctl = 1'b1;
    wait_state(S_IDLE, 6, "to_idle");
    vec++; if (j11abortout !== 1'b0 || buserrcnt !== 8'd1) begin errs++; $display("FAIL to_done: abort %b errcnt %0d required 0 1", j11abortout, buserrcnt); end
  endtask

  task automatic test_buserr();
    int r0 = req_cnt;
    fetch(16'h0E00, 16'h0100, "be");
    wait_state(S_RDREQ, 2, "be_req");
    vec++; if (busgp !== 1'b1) begin errs++; $display("FAIL be_gp: got %b required 1", busgp); end
    @(negedge clk); busack = 1'b1; buserr = 1'b1;
    @(negedge clk); busack = 1'b0; buserr = 1'b0;
    vec++; if (j11state !== S_ABORT || j11abortout !== 1'b1 || buserrcnt !== 8'd2) begin errs++; $display("FAIL be_abort: state %0d abort %b errcnt %0d required %0d 1 2", j11state, j11abortout, buserrcnt, S_ABORT); end
    @(negedge clk);
    vec++; if (j11state !== S_IDLE || req_cnt - r0 != 1) begin errs++; $display("FAIL be_idle: state %0d reqs %0d required %0d 1", j11state, req_cnt - r0, S_IDLE); end
    busack = 1'b1; buserr = 1'b1;
    @(negedge clk); busack = 1'b0; buserr = 1'b0;
    @(negedge clk);
    vec++; if (j11state !== S_IDLE || buserrcnt !== 8'd2) begin errs++; $display("FAIL stray_ack: state %0d errcnt %0d required %0d 2", j11state, buserrcnt, S_IDLE); end
  endtask

  task automatic test_special();
    logic [15:0] hw [3] = '{16'h0F00, 16'h0D00, 16'h2800};
    logic [4:0]  st [3] = '{S_WREND, S_IRQACK, S_WREND};
    int r0 = req_cnt;
    for (int i = 0; i < 3; i++) begin
      fetch(hw[i], 16'h0000, "sp");
      @(negedge clk);
      vec++; if (j11state !== st[i] || j11cont !== (st[i] == S_WREND ? 1'b0 : 1'b1)) begin errs++; $display("FAIL special_%0d: state %0d cont %b required %0d", i, j11state, j11cont, st[i]); end
      wait_state(S_IDLE, 6, "special_idle");
    end
    vec++; if (req_cnt != r0) begin errs++; $display("FAIL special_noreq: %0d requests required 0", req_cnt - r0); end
  endtask

  task automatic test_status();
    logic [15:0] ev [2] = '{16'h0045, 16'h0005};
    logic [4:0]  xs [2] = '{S_IDLE, S_INIT};
    for (int t = 0; t < 2; t++) begin
      if (t == 0) j11irq = 4'h5; else j11init = 1'b0;
      @(negedge clk);
      for (int i = 0; i < FPHASE; i++) begin
        vec++; if (j11state !== S_OUTHI || j11f !== ev[t]) begin errs++; $display("FAIL status%0d_out_%0d: state %0d F %h required %0d %h", t, i, j11state, j11f, S_OUTHI, ev[t]); end
        vec++; if (j11dsel !== ((i == 1 || i == 2) ? D_OUTHI : D_NONE)) begin errs++; $display("FAIL status%0d_dsel_%0d: got %b", t, i, j11dsel); end
        @(negedge clk);
      end
      vec++; if (j11state !== xs[t]) begin errs++; $display("FAIL status%0d_exit: state %0d required %0d", t, j11state, xs[t]); end
    end
    j11init = 1'b1;
    wait_state(S_IDLE, 10, "status_reinit");
  endtask

  task automatic test_concurrent();
    f_hi = 16'h0D00;
    @(negedge clk); j11strb = 1'b1;
    repeat (2) @(negedge clk);
    j11irq = 4'hA;
    @(negedge clk);
    vec++; if (j11state !== S_WAITALE) begin errs++; $display("FAIL conc_priority: state %0d required %0d", j11state, S_WAITALE); end
    j11ale = 1'b0;
    wait_state(S_DECODE, 20, "conc_decode");
    j11ale = 1'b1; j11strb = 1'b0;
    wait_state(S_OUTHI, 6, "conc_outhi");
    vec++; if (j11f !== 16'h004A) begin errs++; $display("FAIL conc_status: F %h required 004a", j11f); end
    wait_state(S_IDLE, 8, "conc_idle");
  endtask

  task automatic test_reset_mid();
    fetch(16'h0800, 16'h0010, "rm");
    wait_state(S_RDREQ, 2, "rm_req");
    busack = 1'b1; busrdata = 16'hBEEF;
    @(negedge clk); busack = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    vec++; if (j11state !== S_INIT || j11dsel !== D_NONE || j11f === 16'hBEEF) begin errs++; $display("FAIL rm_async: state %0d dsel %b F %h required %0d %b released", j11state, j11dsel, j11f, S_INIT, D_NONE); end
    vec++; if (busaddr !== 22'h0 || buserrcnt !== 8'h0 || j11cont !== 1'b1) begin errs++; $display("FAIL rm_regs: addr %h errcnt %0d cont %b required 0 0 1", busaddr, buserrcnt, j11cont); end
    @(negedge clk); rstn = 1'b1;
    wait_state(S_IDLE, 20, "rm_idle");
  endtask

  initial begin
    rstn = 1'b0; j11ale = 1'b1; j11strb = 1'b0; j11sctl = 1'b1; j11map = 1'b1;
    j11irq = 4'h0; j11init = 1'b1; j11halt = 1'b0; j11pwrf = 1'b0; j11fpe = 1'b0;
    j11event = 1'b0; j11parity = 1'b0; busack = 1'b0; buserr = 1'b0; busrdata = 16'h0;
    test_reset();
    test_clkdiv();
    test_read();
    test_write();
    test_timeout();
    test_buserr();
    test_special();
    test_status();
    test_concurrent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
